// File: rtl/psram_async_responder_if.sv
// Pin-level bundle for the asynchronous PSRAM/SRAM strobe interface.
// master = initiator side, slave = responder side.
interface psram_async_responder_if #(
  parameter int DATAW = 16,
  parameter int ADRW  = 12
);
  logic             ce_n_i;
  logic             we_n_i;
  logic             oe_n_i;
  logic [ADRW-1:0]  adr_i;
  logic [DATAW-1:0] dat_i;
  logic [DATAW-1:0] dat_o;
  logic             dat_oe_o;
  logic             busy_o;

  modport master (
    output ce_n_i, we_n_i, oe_n_i, adr_i, dat_i,
    input  dat_o, dat_oe_o, busy_o
  );

  modport slave (
    input  ce_n_i, we_n_i, oe_n_i, adr_i, dat_i,
    output dat_o, dat_oe_o, busy_o
  );
endinterface

// File: rtl/psram_async_responder.sv
// Device-side responder for the async PSRAM ce/we/oe protocol, oversampled on clk_i.
// Optional protocol checker (err_o/err_code_o) enabled by PSRAM_ASYNC_RESPONDER_CHECK_EN.
module psram_async_responder #(
  parameter int DATAW       = 16,
  parameter int ADRW        = 12,
  parameter int SYNC_STAGES = 2,
  parameter int ACCESS_CYC  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  psram_async_responder_if.slave   bus
`ifdef PSRAM_ASYNC_RESPONDER_CHECK_EN
  ,
  output logic                     err_o,
  output logic [1:0]               err_code_o
`endif
);

  localparam int SYNCW = 3 + ADRW + DATAW;
  localparam int STG   = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int CNTW  = (ACCESS_CYC < 1) ? 1 : $clog2(ACCESS_CYC + 1);
  localparam logic [SYNCW-1:0] SYNC_RST = {3'b111, {(ADRW + DATAW){1'b0}}};
  localparam logic [CNTW-1:0]  CNT_LOAD = CNTW'(ACCESS_CYC);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_DRIVE,
    WR_ACTIVE,
    WR_COMMIT
  } state_t;

  logic [SYNCW-1:0] sync_q [STG];
  logic [SYNCW-1:0] sync_d [STG];

  logic             s_ce_n, s_we_n, s_oe_n;
  logic [ADRW-1:0]  s_adr;
  logic [DATAW-1:0] s_dat;

  state_t           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [ADRW-1:0]  adr_q, adr_d;
  logic [DATAW-1:0] wdat_q, wdat_d;
  logic [DATAW-1:0] dat_q, dat_d;
  logic             oe_q, oe_d;
  logic             mem_we;
  logic             rd_abort;

  logic [DATAW-1:0] mem [2**ADRW];

  // All pins share one chain so strobes, address and data stay cycle-aligned.
  always_comb begin
    sync_d[0] = {bus.ce_n_i, bus.we_n_i, bus.oe_n_i, bus.adr_i, bus.dat_i};
    for (int i = 1; i < STG; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < STG; i++) begin
        sync_q[i] <= SYNC_RST;
      end
    end else begin
      for (int i = 0; i < STG; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign {s_ce_n, s_we_n, s_oe_n, s_adr, s_dat} = sync_q[STG-1];

  // A falling we during a read also aborts; the write is then picked up from IDLE.
  assign rd_abort = s_ce_n | s_oe_n | ~s_we_n;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    dat_d   = dat_q;
    oe_d    = oe_q;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!s_ce_n && !s_we_n) begin
          state_d = WR_ACTIVE;
          adr_d   = s_adr;
          wdat_d  = s_dat;
        end else if (!s_ce_n && !s_oe_n) begin
          state_d = RD_WAIT;
          adr_d   = s_adr;
          cnt_d   = CNT_LOAD;
        end
      end
      RD_WAIT: begin
        if (rd_abort) begin
          state_d = IDLE;
          oe_d    = 1'b0;
        end else if (cnt_q == '0) begin
          state_d = RD_DRIVE;
          dat_d   = mem[adr_q];
          oe_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      RD_DRIVE: begin
        if (rd_abort) begin
          state_d = IDLE;
          oe_d    = 1'b0;
        end else if (s_adr != adr_q) begin
          state_d = RD_WAIT;
          adr_d   = s_adr;
          oe_d    = 1'b0;
          cnt_d   = CNT_LOAD;
        end
      end
      WR_ACTIVE: begin
        if (!s_ce_n && !s_we_n) begin
          adr_d  = s_adr;
          wdat_d = s_dat;
        end else begin
          state_d = WR_COMMIT;
        end
      end
      WR_COMMIT: begin
        mem_we  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      dat_q   <= '0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      dat_q   <= dat_d;
      oe_q    <= oe_d;
    end
  end

  // Array is deliberately left out of reset so contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[adr_q] <= wdat_q;
    end
  end

  assign bus.dat_o    = dat_q;
  assign bus.dat_oe_o = oe_q;
  assign bus.busy_o   = (state_q != IDLE);

`ifdef PSRAM_ASYNC_RESPONDER_CHECK_EN
  logic       err_q, err_d;
  logic [1:0] code_q, code_d;

  // Only the first violation is recorded; later ones leave the code untouched.
  always_comb begin
    err_d  = err_q;
    code_d = code_q;
    if (!err_q) begin
      if (state_q == WR_ACTIVE && !s_oe_n) begin
        err_d  = 1'b1;
        code_d = 2'd2;
      end else if (state_q == WR_ACTIVE && !s_ce_n && !s_we_n && s_adr != adr_q) begin
        err_d  = 1'b1;
        code_d = 2'd1;
      end else if (state_q == RD_WAIT && (s_ce_n || s_oe_n) && cnt_q != '0) begin
        err_d  = 1'b1;
        code_d = 2'd3;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q  <= 1'b0;
      code_q <= 2'd0;
    end else begin
      err_q  <= err_d;
      code_q <= code_d;
    end
  end

  assign err_o      = err_q;
  assign err_code_o = code_q;
`endif

endmodule
